exc_seq_ctrl: RTL
=================

Name: exc_seq_ctrl

Overview:
- Exception/ERET sequencer between the ID stage and the CP0 register file of the simple pipeline.
- Detects SYSCALL, BREAK, TEQ-taken and ERET in ID, then gates each against the CP0 status word.
- For an accepted event: stalls the front end, drains EX/MEM/WB, issues a one-cycle exception or eret command to CP0, then redirects the PC to CP0's exc_addr.
- Also keeps a saturating count of exceptions taken and a sticky drain-timeout flag.

Parameters:
- DRAIN_MAX, 15: cycles to wait in DRAIN for pipe_empty before proceeding anyway.
- CNT_W, 16: width of exc_count.

Ports:
- clk  in  1  system clock; posedge-triggered.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID holds a valid instruction.
- id_pc  in  32  PC of the ID instruction.
- id_syscall  in  1  ID decodes SYSCALL.
- id_break  in  1  ID decodes BREAK.
- id_teq  in  1  ID decodes TEQ.
- teq_eq  in  1  TEQ operands equal.
- id_eret  in  1  ID decodes ERET.
- status_in  in  32  CP0 status register.
- pipe_empty  in  1  EX/MEM/WB hold no valid instruction.
- cp0_exception  out  1  one-cycle exception command to CP0.
- cp0_eret  out  1  one-cycle eret command to CP0.
- cp0_pc  out  32  latched PC of the faulting instruction.
- cp0_cause  out  4  latched cause code.
- stall  out  1  hold IF/ID registers.
- flush  out  1  squash IF/ID contents.
- pc_redirect  out  1  PC loads CP0 exc_addr this cycle.
- busy  out  1  state != IDLE.
- drain_timeout  out  1  sticky; cleared only by rst.
- exc_count  out  CNT_W  saturating count of exceptions taken.

Behaviour:
- Cause codes: SYS = 4'b1000, BREAK = 4'b1001, TEQ = 4'b1101.
- Enable terms: en = status_in[0]. sys_ok = id_syscall & status_in[1]. brk_ok = id_break & status_in[2]. teq_ok = id_teq & teq_eq & status_in[3].
- Acceptance, evaluated in IDLE only: accept = id_valid & (eret_req | en & (sys_ok | brk_ok | teq_ok)), with eret_req = id_eret.
- Priority when several flags are set: SYSCALL > BREAK > TEQ > ERET.
- Masked or untaken events: no stall, no CP0 command, treated as a NOP.
- On the accept edge, latch: cp0_pc <= id_pc; cp0_cause <= chosen code (4'b0000 for ERET); kind bit (exception vs eret).
- stall = accept | (state != IDLE). It is combinational, so the ID stage freezes in the accept cycle T.
- State machine:
  - IDLE: on accept, go to DRAIN and clear drain_cnt.
  - DRAIN: flush = 1 (IF/ID squashed). If pipe_empty, go to COMMIT. Else if drain_cnt == DRAIN_MAX-1, set drain_timeout and go to COMMIT. Else drain_cnt++.
  - COMMIT: for one cycle, cp0_exception = kind_exc or cp0_eret = ~kind_exc. CP0 writes on the negedge of the same cycle. Go to REDIRECT.
  - REDIRECT: pc_redirect = 1 and flush = 1 for one cycle. Go to IDLE.
- Timing when pipe_empty is already high at T+1: DRAIN at T+1, COMMIT at T+2, REDIRECT at T+3, IDLE at T+4. Minimum stall is 4 cycles.
- exc_count increments in COMMIT only for exceptions, not for ERET; it saturates at all-ones.
- Requests arriving while busy are ignored; they are held in ID by stall and re-evaluated in IDLE.
- cp0_exception and cp0_eret are never high in the same cycle.
- Reset (asynchronous, any state):
  - state = IDLE; all pulses and stall = 0.
  - cp0_pc = 0, cp0_cause = 0, exc_count = 0, drain_timeout = 0, drain_cnt = 0.
  - Reset mid-sequence aborts it, and no CP0 command is issued afterwards.

Decomposition:
- Package exc_pkg holds: cause constants SYS/BREAK/TEQ, the status bit indices (0..3), and the state encoding (IDLE, DRAIN, COMMIT, REDIRECT).
- One natural sub-module, exc_prio_enc: the combinational priority/enable encoder producing accept, kind and cause.

Test Plan:
1. SYSCALL, status = 32'h3, id_pc = 32'h00400020, pipe_empty = 1 → stall for 4 cycles; cp0_exception pulses at T+2 with cp0_pc = 32'h00400020 and cp0_cause = 4'b1000; pc_redirect pulses at T+3; exc_count = 1.
2. BREAK with status = 32'h1 (bit 2 clear) → no stall, no pulses, exc_count = 0.
3. TEQ with teq_eq = 1, status = 32'h9, pipe_empty low for 3 cycles → DRAIN lasts 3 cycles; cp0_cause = 4'b1101; drain_timeout stays 0.
4. ERET with status = 0 → accepted; cp0_eret pulses once with cp0_cause = 0; cp0_exception stays 0; exc_count unchanged.
5. SYSCALL with pipe_empty stuck 0 → COMMIT after exactly 15 DRAIN cycles; drain_timeout = 1 and stays 1 afterwards.
6. rst asserted in DRAIN after syscall + break set together → all outputs 0 immediately; no cp0_exception afterwards. Repeating the request without reset yields cause 4'b1000, since SYSCALL wins priority.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared constants for the exception/ERET sequencer.
// Holds the CP0 cause codes, the CP0 status bit positions that gate each event,
// the sequencer state encoding and the request record produced by the encoder.
package exc_pkg;

  // CP0 cause codes; ERET carries no cause.
  localparam logic [3:0] CAUSE_NONE  = 4'b0000;
  localparam logic [3:0] CAUSE_SYS   = 4'b1000;
  localparam logic [3:0] CAUSE_BREAK = 4'b1001;
  localparam logic [3:0] CAUSE_TEQ   = 4'b1101;

  // Status word bit positions.
  localparam int unsigned STATUS_EN_BIT  = 0;  // global exception enable
  localparam int unsigned STATUS_SYS_BIT = 1;
  localparam int unsigned STATUS_BRK_BIT = 2;
  localparam int unsigned STATUS_TEQ_BIT = 3;

  // Sequencer state encoding.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DRAIN    = 2'd1;
  localparam logic [1:0] ST_COMMIT   = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  // Decoded request from the ID stage.
  typedef struct packed {
    logic       accept;    // event is taken
    logic       kind_exc;  // 1: exception, 0: eret
    logic [3:0] cause;     // cause code to hand to CP0
  } exc_req_t;

endpackage

// File: rtl/exc_seq_ctrl_if.sv
// Bundle of the sequencer's ID-stage, CP0 and pipeline-control signals.
//   slave  : the sequencer (consumes ID/status/pipe state, drives CP0 + control)
//   master : the surrounding pipeline (drives ID/status/pipe state)
// Signals:
//   id_valid, id_pc, id_syscall, id_break, id_teq, teq_eq, id_eret : ID stage decode
//   status_in  : CP0 status word
//   pipe_empty : EX/MEM/WB hold no valid instruction
//   cp0_exception, cp0_eret, cp0_pc, cp0_cause : one-cycle CP0 command + payload
//   stall, flush, pc_redirect : front-end control
//   busy, drain_timeout, exc_count : status
interface exc_seq_ctrl_if #(
  parameter int unsigned CNT_W = 16
);

  logic             id_valid;
  logic [31:0]      id_pc;
  logic             id_syscall;
  logic             id_break;
  logic             id_teq;
  logic             teq_eq;
  logic             id_eret;
  logic [31:0]      status_in;
  logic             pipe_empty;

  logic             cp0_exception;
  logic             cp0_eret;
  logic [31:0]      cp0_pc;
  logic [3:0]       cp0_cause;
  logic             stall;
  logic             flush;
  logic             pc_redirect;
  logic             busy;
  logic             drain_timeout;
  logic [CNT_W-1:0] exc_count;

  modport slave (
    input  id_valid, id_pc, id_syscall, id_break, id_teq, teq_eq, id_eret,
    input  status_in, pipe_empty,
    output cp0_exception, cp0_eret, cp0_pc, cp0_cause,
    output stall, flush, pc_redirect, busy, drain_timeout, exc_count
  );

  modport master (
    output id_valid, id_pc, id_syscall, id_break, id_teq, teq_eq, id_eret,
    output status_in, pipe_empty,
    input  cp0_exception, cp0_eret, cp0_pc, cp0_cause,
    input  stall, flush, pc_redirect, busy, drain_timeout, exc_count
  );

endinterface

// File: rtl/exc_prio_enc.sv
// Combinational priority/enable encoder for ID-stage exception events.
// Gates SYSCALL/BREAK/TEQ by the status enables and picks the winner in the
// order SYSCALL > BREAK > TEQ > ERET. ERET is never masked by status.
// Ports:
//   id_valid, id_syscall, id_break, id_teq, teq_eq, id_eret : ID decode
//   status_bits : status_in[3:0]
//   req         : accept / kind_exc / cause
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic       id_valid,
  input  logic       id_syscall,
  input  logic       id_break,
  input  logic       id_teq,
  input  logic       teq_eq,
  input  logic       id_eret,
  input  logic [3:0] status_bits,
  output exc_req_t   req
);

  logic en;
  logic sys_ok;
  logic brk_ok;
  logic teq_ok;

  assign en     = status_bits[STATUS_EN_BIT];
  assign sys_ok = en & id_syscall & status_bits[STATUS_SYS_BIT];
  assign brk_ok = en & id_break & status_bits[STATUS_BRK_BIT];
  assign teq_ok = en & id_teq & teq_eq & status_bits[STATUS_TEQ_BIT];

  // A masked higher-priority flag does not block a lower enabled one.
  always_comb begin
    req.accept   = 1'b0;
    req.kind_exc = 1'b0;
    req.cause    = CAUSE_NONE;
    if (id_valid) begin
      if (sys_ok) begin
        req.accept   = 1'b1;
        req.kind_exc = 1'b1;
        req.cause    = CAUSE_SYS;
      end else if (brk_ok) begin
        req.accept   = 1'b1;
        req.kind_exc = 1'b1;
        req.cause    = CAUSE_BREAK;
      end else if (teq_ok) begin
        req.accept   = 1'b1;
        req.kind_exc = 1'b1;
        req.cause    = CAUSE_TEQ;
      end else if (id_eret) begin
        req.accept   = 1'b1;
        req.kind_exc = 1'b0;
        req.cause    = CAUSE_NONE;
      end
    end
  end

endmodule

// File: rtl/exc_seq_ctrl.sv
// Exception/ERET sequencer between ID and the CP0 register file.
// An accepted event stalls the front end, drains EX/MEM/WB (bounded by
// DRAIN_MAX cycles), issues a one-cycle exception/eret command to CP0 and then
// redirects the PC to CP0's exc_addr. Keeps a saturating exception count and a
// sticky drain-timeout flag.
// Ports:
//   clk : posedge clock
//   rst : asynchronous active-high reset
//   bus : exc_seq_ctrl_if.slave (ID decode, status, pipe_empty in;
//         CP0 command, stall/flush/pc_redirect, busy/drain_timeout/exc_count out)
module exc_seq_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned DRAIN_MAX = 15,
  parameter int unsigned CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  exc_seq_ctrl_if.slave bus
);

  localparam int unsigned DCNT_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_MAX - 1);

  exc_req_t req;

  logic [1:0]        state_q, state_d;
  logic [DCNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [31:0]       cp0_pc_q, cp0_pc_d;
  logic [3:0]        cp0_cause_q, cp0_cause_d;
  logic              kind_exc_q, kind_exc_d;
  logic [CNT_W-1:0]  exc_count_q, exc_count_d;
  logic              drain_timeout_q, drain_timeout_d;
  logic              accept_idle;
  logic              unused_status;

  assign unused_status = ^bus.status_in[31:4];

  exc_prio_enc u_prio_enc (
    .id_valid    (bus.id_valid),
    .id_syscall  (bus.id_syscall),
    .id_break    (bus.id_break),
    .id_teq      (bus.id_teq),
    .teq_eq      (bus.teq_eq),
    .id_eret     (bus.id_eret),
    .status_bits (bus.status_in[3:0]),
    .req         (req)
  );

  // Requests are only looked at in IDLE; while busy the instruction is held in
  // ID by stall and re-evaluated once the sequence completes. Reset also masks
  // the combinational stall path.
  assign accept_idle = (state_q == ST_IDLE) & req.accept & ~rst;

  always_comb begin
    state_d         = state_q;
    drain_cnt_d     = drain_cnt_q;
    cp0_pc_d        = cp0_pc_q;
    cp0_cause_d     = cp0_cause_q;
    kind_exc_d      = kind_exc_q;
    exc_count_d     = exc_count_q;
    drain_timeout_d = drain_timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req.accept) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
          cp0_pc_d    = bus.id_pc;
          cp0_cause_d = req.cause;
          kind_exc_d  = req.kind_exc;
        end
      end
      ST_DRAIN: begin
        if (bus.pipe_empty) begin
          state_d = ST_COMMIT;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          // Give up waiting; CP0 is committed with the pipe still busy.
          drain_timeout_d = 1'b1;
          state_d         = ST_COMMIT;
        end else begin
          drain_cnt_d = drain_cnt_q + DCNT_W'(1);
        end
      end
      ST_COMMIT: begin
        state_d = ST_REDIRECT;
        if (kind_exc_q && (exc_count_q != '1)) begin
          exc_count_d = exc_count_q + CNT_W'(1);
        end
      end
      ST_REDIRECT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      drain_cnt_q     <= '0;
      cp0_pc_q        <= '0;
      cp0_cause_q     <= CAUSE_NONE;
      kind_exc_q      <= 1'b0;
      exc_count_q     <= '0;
      drain_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      drain_cnt_q     <= drain_cnt_d;
      cp0_pc_q        <= cp0_pc_d;
      cp0_cause_q     <= cp0_cause_d;
      kind_exc_q      <= kind_exc_d;
      exc_count_q     <= exc_count_d;
      drain_timeout_q <= drain_timeout_d;
    end
  end

  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.stall         = accept_idle | bus.busy;
  assign bus.flush         = (state_q == ST_DRAIN) | (state_q == ST_REDIRECT);
  assign bus.pc_redirect   = (state_q == ST_REDIRECT);
  // kind_exc selects exactly one of the two commands, so they never overlap.
  assign bus.cp0_exception = (state_q == ST_COMMIT) & kind_exc_q;
  assign bus.cp0_eret      = (state_q == ST_COMMIT) & ~kind_exc_q;
  assign bus.cp0_pc        = cp0_pc_q;
  assign bus.cp0_cause     = cp0_cause_q;
  assign bus.exc_count     = exc_count_q;
  assign bus.drain_timeout = drain_timeout_q;

endmodule
